oven_ctrl_param: RTL and testbench
==================================

// Module: oven_ctrl_param
// PURPOSE
//  Parametrised successor oven controller. Owns the 1 Hz tick, the MM:SS wall clock, the target-temp and bake-time settings,
//  a first-order oven temperature model and the preheat/bake/done FSM.
//  Drives four BCD digits to the existing sevenseg decoders plus heater/done flags; sits between board switches/buttons and the HEX displays.
// PARAMETERS
//  CLK_HZ       50_000_000  clk cycles per 1 s tick (sim uses 10)
//  TEMP_W       11          width of temperature registers
//  TEMP_MIN     60          lowest settable target; also ambient temp
//  TEMP_MAX     900         highest settable target
//  TEMP_STEP    10          target change per up/down press
//  TEMP_INIT    300         target after reset
//  HEAT_RATE    2           deg/tick rise while heater=1
//  COOL_RATE    1           deg/tick fall while heater=0 (floor TEMP_MIN)
//  TIME_STEP    60          bake-time change per press, seconds
//  TIME_MAX     3600        max bake time, seconds (displays 60:00)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  power      in   1  level: 1 = oven on, 0 = off (show wall clock)
//  sel_time   in   1  level: 1 = up/down edit bake time, 0 = edit target temp
//  btn_up     in   1  debounced, synchronous; rising edge = increment
//  btn_down   in   1  debounced, synchronous; rising edge = decrement
//  btn_start  in   1  debounced, synchronous; rising edge = start / acknowledge
//  heater     out  1  heating element enable
//  done       out  1  bake complete alarm
//  state      out  3  FSM state code (debug/LED)
//  bcd3..bcd0 out  4  display digits, bcd3 leftmost
// BEHAVIOUR
//  Reset: state=OFF, heater=0, done=0, clock=00:00, target=TEMP_INIT, bake_time=0, remain=0, temp=TEMP_MIN, tick counter=0, edge regs=0.
//  Tick: 1-cycle pulse when counter==CLK_HZ-1, counter then wraps to 0; first tick CLK_HZ cycles after reset release.
//  Wall clock: free-running MM:SS in BCD on every tick in every state; 59:59 -> 00:00.
//  Edges: each button registered once; edge = cur & ~prev. Setting updates on the clk edge after edge detect (2nd edge after input rise).
//  States: OFF=0, SET=1, PREHEAT=2, BAKE=3, DONE=4.
//   OFF:     power=1 -> SET. Display wall clock MM:SS. heater=0.
//   SET:     up/down edit target (sel_time=0) or bake_time (sel_time=1). start edge with bake_time>0 -> PREHEAT, remain<=bake_time;
//            start with bake_time==0 ignored. Display: temp mode 0HHH of target; time mode MM:SS of bake_time.
//   PREHEAT: heater=1 while temp<target. temp>=target -> BAKE. Display current temp 0HHH.
//   BAKE:    heater = (temp<target) (bang-bang hold). remain-- on each tick; remain reaching 0 -> DONE. Display remain MM:SS.
//   DONE:    heater=0, done=1, display 0000. start edge -> SET (done cleared).
//   Any state except OFF: power=0 -> OFF next edge; heater=0, done=0; target and bake_time retained, remain cleared.
//  Edits only act in SET; up/down edges in other states are ignored.
//  Saturation: target clamps to [TEMP_MIN,TEMP_MAX]; bake_time clamps to [0,TIME_MAX]; no wrap.
//   E.g. target 895 + step -> 900.
//  Simultaneous up and down edges in same cycle: no change.
//  Temp model on tick: heater=1 -> temp=min(temp+HEAT_RATE, TEMP_MAX); heater=0 -> temp=max(temp-COOL_RATE, TEMP_MIN). Runs in all states.
//  Display math: minutes=val/60, seconds=val%60, each split into tens/units; 3600 -> 6,0,0,0. Temp: bcd2=hundreds, bcd1=tens, bcd0=units, bcd3=0.
//  heater, done, state and bcd* are registered; changes appear one cycle after the causing state/value update.
//  Reset asserted mid-bake: immediate return to reset values, heater drops asynchronously.
// TESTING (CLK_HZ=10)
//  1 rst, power=0, run 125 ticks -> bcd shows 02:05; run to 3600 ticks -> wraps to 00:00.
//  2 power=1, sel_time=0, 70 up edges -> target saturates at 900; 90 down edges -> 60; up+down same cycle -> unchanged.
//  3 sel_time=1, 2 up edges (bake 120), start -> PREHEAT, heater=1; temp 60->300 in 120 ticks -> BAKE, display 02:00 counting down.
//  4 From 3, at remain 00:01 one tick -> DONE, done=1, heater=0, display 0000; start edge -> SET, done=0.
//  5 bake_time=0, start edge -> stays SET; power=0 during BAKE -> OFF, heater=0 next cycle, settings retained on power=1.
//  6 Assert rst mid-BAKE between clk edges -> heater=0 immediately, state=OFF, target=300.

Source files
------------

// File: rtl/oven_ctrl_param.sv
// Parametrised oven controller: 1 Hz tick, MM:SS wall clock, temperature model
// and preheat/bake/done sequencing, driving four BCD display digits.
module oven_ctrl_param #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TEMP_W    = 11,
    parameter int TEMP_MIN  = 60,
    parameter int TEMP_MAX  = 900,
    parameter int TEMP_STEP = 10,
    parameter int TEMP_INIT = 300,
    parameter int HEAT_RATE = 2,
    parameter int COOL_RATE = 1,
    parameter int TIME_STEP = 60,
    parameter int TIME_MAX  = 3600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic       sel_time,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    output logic       heater,
    output logic       done,
    output logic [2:0] state,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0
);
    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_SET  = 3'd1,
        S_PRE  = 3'd2,
        S_BAKE = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int CNT_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TIME_W = ($clog2(TIME_MAX + 1) > 12) ? $clog2(TIME_MAX + 1) : 12;
    localparam int DV_W   = 16;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_HZ - 1);
    localparam logic [TEMP_W-1:0] T_MIN    = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] T_MAX    = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0] T_STEP   = TEMP_W'(TEMP_STEP);
    localparam logic [TEMP_W-1:0] T_INIT   = TEMP_W'(TEMP_INIT);
    localparam logic [TEMP_W-1:0] T_HEAT   = TEMP_W'(HEAT_RATE);
    localparam logic [TEMP_W-1:0] T_COOL   = TEMP_W'(COOL_RATE);
    localparam logic [TIME_W-1:0] B_STEP   = TIME_W'(TIME_STEP);
    localparam logic [TIME_W-1:0] B_MAX    = TIME_W'(TIME_MAX);
    localparam logic [TIME_W-1:0] W_LAST   = TIME_W'(3599);

    state_t              fsm, fsm_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic [TIME_W-1:0]   wall;
    logic [TEMP_W-1:0]   target, target_nxt;
    logic [TIME_W-1:0]   bake, bake_nxt;
    logic [TIME_W-1:0]   remain, remain_nxt;
    logic [TEMP_W-1:0]   temp;
    logic [TEMP_W:0]     heat_sum;
    logic [TEMP_W-1:0]   temp_up, temp_dn;
    logic                cur_up, cur_dn, cur_st;
    logic                prev_up, prev_dn, prev_st;
    logic                up_e, dn_e, st_e, inc, dec;
    logic                time_mode;
    logic [DV_W-1:0]     dval, mins, secs;
    logic [3:0]          d3, d2, d1, d0;

    assign tick = (cnt == CNT_LAST);
    assign up_e = cur_up & ~prev_up;
    assign dn_e = cur_dn & ~prev_dn;
    assign st_e = cur_st & ~prev_st;
    assign inc  = up_e & ~dn_e;
    assign dec  = dn_e & ~up_e;

    always_comb begin
        fsm_nxt    = fsm;
        target_nxt = target;
        bake_nxt   = bake;
        remain_nxt = remain;
        unique case (fsm)
            S_OFF: if (power) fsm_nxt = S_SET;
            S_SET: begin
                if (inc && !sel_time)
                    target_nxt = (target > T_MAX - T_STEP) ? T_MAX : target + T_STEP;
                if (dec && !sel_time)
                    target_nxt = (target < T_MIN + T_STEP) ? T_MIN : target - T_STEP;
                if (inc && sel_time)
                    bake_nxt = (bake > B_MAX - B_STEP) ? B_MAX : bake + B_STEP;
                if (dec && sel_time)
                    bake_nxt = (bake < B_STEP) ? '0 : bake - B_STEP;
                if (st_e && bake != '0) begin
                    fsm_nxt    = S_PRE;
                    remain_nxt = bake;
                end
            end
            S_PRE: if (temp >= target) fsm_nxt = S_BAKE;
            S_BAKE: begin
                if (tick) begin
                    remain_nxt = (remain == '0) ? '0 : remain - 1'b1;
                    if (remain <= TIME_W'(1)) fsm_nxt = S_DONE;
                end
            end
            S_DONE: if (st_e) fsm_nxt = S_SET;
            default: fsm_nxt = S_OFF;
        endcase
        // power-off wins from every state and abandons any bake in progress
        if (!power) begin
            fsm_nxt    = S_OFF;
            remain_nxt = '0;
        end
    end

    assign heat_sum = {1'b0, temp} + {1'b0, T_HEAT};
    assign temp_up  = (heat_sum > {1'b0, T_MAX}) ? T_MAX : heat_sum[TEMP_W-1:0];
    assign temp_dn  = (temp < T_MIN + T_COOL) ? T_MIN : temp - T_COOL;

    always_comb begin
        time_mode = 1'b1;
        dval      = '0;
        unique case (fsm)
            S_SET: begin
                time_mode = sel_time;
                dval      = sel_time ? DV_W'(bake) : DV_W'(target);
            end
            S_PRE: begin
                time_mode = 1'b0;
                dval      = DV_W'(temp);
            end
            S_BAKE:  dval = DV_W'(remain);
            S_DONE:  dval = '0;
            default: dval = DV_W'(wall);
        endcase
        mins = dval / DV_W'(60);
        secs = dval % DV_W'(60);
        if (time_mode) begin
            d3 = 4'(mins / DV_W'(10));
            d2 = 4'(mins % DV_W'(10));
            d1 = 4'(secs / DV_W'(10));
            d0 = 4'(secs % DV_W'(10));
        end else begin
            d3 = 4'd0;
            d2 = 4'(dval / DV_W'(100));
            d1 = 4'((dval / DV_W'(10)) % DV_W'(10));
            d0 = 4'(dval % DV_W'(10));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= S_OFF;
            cnt     <= '0;
            wall    <= '0;
            target  <= T_INIT;
            bake    <= '0;
            remain  <= '0;
            temp    <= T_MIN;
            cur_up  <= 1'b0;
            cur_dn  <= 1'b0;
            cur_st  <= 1'b0;
            prev_up <= 1'b0;
            prev_dn <= 1'b0;
            prev_st <= 1'b0;
            heater  <= 1'b0;
            done    <= 1'b0;
            state   <= 3'd0;
            bcd3    <= 4'd0;
            bcd2    <= 4'd0;
            bcd1    <= 4'd0;
            bcd0    <= 4'd0;
        end else begin
            fsm     <= fsm_nxt;
            cnt     <= tick ? '0 : cnt + 1'b1;
            target  <= target_nxt;
            bake    <= bake_nxt;
            remain  <= remain_nxt;
            cur_up  <= btn_up;
            cur_dn  <= btn_down;
            cur_st  <= btn_start;
            prev_up <= cur_up;
            prev_dn <= cur_dn;
            prev_st <= cur_st;
            if (tick) begin
                wall <= (wall == W_LAST) ? '0 : wall + 1'b1;
                temp <= heater ? temp_up : temp_dn;
            end
            heater  <= (fsm == S_PRE || fsm == S_BAKE) && (temp < target);
            done    <= (fsm == S_DONE);
            state   <= fsm;
            bcd3    <= d3;
            bcd2    <= d2;
            bcd1    <= d1;
            bcd0    <= d0;
        end
    end
endmodule

// File: tb/tb_oven_ctrl_param.sv
// Scoreboard bench for oven_ctrl_param at CLK_HZ=10: wall clock, settings,
// preheat/bake/done sequence, power-off and asynchronous reset.
module tb_oven_ctrl_param;
    localparam int K_BCD = 0;
    localparam int K_ST  = 1;
    localparam int K_HT  = 2;
    localparam int K_DN  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       power = 1'b0;
    logic       sel_time = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_start = 1'b0;
    logic       heater, done;
    logic [2:0] state;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;

    typedef struct {
        int    kind;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_target = 300;
    int   m_bake = 0;
    int   n;

    oven_ctrl_param #(.CLK_HZ(10)) dut (
        .clk(clk), .rst(rst), .power(power), .sel_time(sel_time),
        .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
        .heater(heater), .done(done), .state(state),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int observe(int kind);
        case (kind)
            K_BCD:   return int'({bcd3, bcd2, bcd1, bcd0});
            K_ST:    return int'(state);
            K_HT:    return int'(heater);
            default: return int'(done);
        endcase
    endfunction

    function automatic int temp_bcd(int t);
        return (((t / 100) % 10) << 8) | (((t / 10) % 10) << 4) | (t % 10);
    endfunction

    function automatic int time_bcd(int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return ((m / 10) << 12) | ((m % 10) << 8) | ((x / 10) << 4) | (x % 10);
    endfunction

    task automatic expect_out(int kind, int val, string tag);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic step(int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // 0 up, 1 down, 2 start, 3 up+down together
    task automatic press(int which);
        btn_up    = (which == 0 || which == 3);
        btn_down  = (which == 1 || which == 3);
        btn_start = (which == 2);
        step(2);
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_start = 1'b0;
        step(2);
    endtask

    task automatic wait_for(int kind, int val, int budget, string tag, output int cnt);
        cnt = 0;
        while (observe(kind) != val && cnt < budget) begin
            step(1);
            cnt++;
        end
        expect_out(kind, val, tag);
        drain();
    endtask

    task automatic tgt_press(int which);
        press(which);
        if (which == 0) m_target = (m_target + 10 > 900) ? 900 : m_target + 10;
        if (which == 1) m_target = (m_target - 10 < 60) ? 60 : m_target - 10;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        expect_out(K_ST, 0, "rst_state");
        expect_out(K_HT, 0, "rst_heater");
        expect_out(K_DN, 0, "rst_done");
        expect_out(K_BCD, 16'h0000, "rst_bcd");
        drain();

        step(1251);
        expect_out(K_BCD, time_bcd(125), "wall_125");
        drain();
        step(34740);
        expect_out(K_BCD, 16'h5959, "wall_3599");
        drain();
        step(10);
        expect_out(K_BCD, 16'h0000, "wall_wrap");
        drain();

        power = 1'b1;
        step(2);
        expect_out(K_ST, 1, "set_state");
        expect_out(K_BCD, temp_bcd(m_target), "set_target");
        drain();
        for (int i = 0; i < 70; i++) begin
            tgt_press(0);
            if (i == 0) begin
                expect_out(K_BCD, temp_bcd(m_target), "target_first_up");
                drain();
            end
        end
        expect_out(K_BCD, 16'h0900, "target_max");
        drain();
        for (int i = 0; i < 90; i++) tgt_press(1);
        expect_out(K_BCD, 16'h0060, "target_min");
        drain();
        tgt_press(0);
        tgt_press(3);
        expect_out(K_BCD, temp_bcd(m_target), "target_up_down");
        drain();
        for (int i = 0; i < 23; i++) tgt_press(0);
        expect_out(K_BCD, 16'h0300, "target_back");
        drain();

        sel_time = 1'b1;
        step(2);
        press(2);
        expect_out(K_ST, 1, "start_zero_bake");
        expect_out(K_BCD, time_bcd(m_bake), "bake_zero");
        drain();
        for (int i = 0; i < 2; i++) begin
            press(0);
            m_bake += 60;
        end
        expect_out(K_BCD, 16'h0200, "bake_120");
        drain();

        press(2);
        expect_out(K_ST, 2, "preheat_state");
        expect_out(K_HT, 1, "preheat_heater");
        expect_out(K_BCD, temp_bcd(60), "preheat_temp");
        drain();
        wait_for(K_ST, 3, 1300, "bake_state", n);
        check("preheat_ticks", int'(n >= 1192 && n <= 1201), 1);
        expect_out(K_BCD, time_bcd(m_bake), "bake_start_disp");
        expect_out(K_HT, 0, "bake_at_target");
        drain();
        step(10);
        expect_out(K_BCD, time_bcd(m_bake - 1), "bake_countdown");
        drain();

        wait_for(K_BCD, 16'h0001, 1300, "bake_last_sec", n);
        wait_for(K_ST, 4, 15, "done_state", n);
        expect_out(K_DN, 1, "done_flag");
        expect_out(K_HT, 0, "done_heater");
        expect_out(K_BCD, 16'h0000, "done_bcd");
        drain();
        press(2);
        expect_out(K_ST, 1, "ack_state");
        expect_out(K_DN, 0, "ack_done");
        expect_out(K_BCD, time_bcd(m_bake), "ack_bake");
        drain();

        press(2);
        wait_for(K_ST, 3, 400, "bake2_state", n);
        step(3);
        power = 1'b0;
        step(2);
        expect_out(K_ST, 0, "poff_state");
        expect_out(K_HT, 0, "poff_heater");
        expect_out(K_DN, 0, "poff_done");
        drain();
        power = 1'b1;
        step(2);
        expect_out(K_ST, 1, "pon_state");
        expect_out(K_BCD, time_bcd(m_bake), "pon_bake");
        drain();
        sel_time = 1'b0;
        step(2);
        expect_out(K_BCD, temp_bcd(m_target), "pon_target");
        drain();

        press(2);
        wait_for(K_ST, 3, 400, "bake3_state", n);
        wait_for(K_HT, 1, 100, "bake3_heater", n);
        #3;
        rst = 1'b1;
        #1;
        expect_out(K_HT, 0, "arst_heater");
        expect_out(K_ST, 0, "arst_state");
        expect_out(K_DN, 0, "arst_done");
        expect_out(K_BCD, 16'h0000, "arst_bcd");
        drain();
        #2;
        rst = 1'b0;
        step(3);
        expect_out(K_ST, 1, "arst_set");
        expect_out(K_BCD, 16'h0300, "arst_target");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
